// File: rtl/conv_operand_sequencer.sv
// Operand streamer for the CONV/MAC datapath: walks the output/channel/tap loop nest and
// emits one a beat (feature, zero-padded) then one b beat (weight) per tap. Optional perf counters: CONV_SEQ_PERF_EN.
module conv_operand_sequencer #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int INPUT_NB_CHANNELS  = 2,
  parameter int OUTPUT_NB_CHANNELS = 16,
  parameter int KERNEL_SIZE        = 3,
  parameter int STRIDE             = 1,
  parameter int ADDR_WIDTH         = 20
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic                     start,
  input  logic                     conv_mode,
  output logic                     running,
  output logic                     done,
  output logic                     fm_rd_en,
  output logic [ADDR_WIDTH-1:0]    fm_addr,
  input  logic [IO_DATA_WIDTH-1:0] fm_rdata,
  output logic                     k_rd_en,
  output logic [ADDR_WIDTH-1:0]    k_addr,
  input  logic [IO_DATA_WIDTH-1:0] k_rdata,
  output logic [IO_DATA_WIDTH-1:0] a_input,
  output logic                     a_valid,
  input  logic                     a_ready,
  output logic [IO_DATA_WIDTH-1:0] b_input,
  output logic                     b_valid,
  input  logic                     b_ready
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0]              perf_cycles,
  output logic [31:0]              perf_stalls
`endif
);

  // state  | meaning
  // IDLE   | waiting for start
  // RD_A   | fm read strobe for current tap (skipped when padded)
  // CAP_A  | capture fm word (or 0) into a_input, raise a_valid
  // HOLD_A | hold a beat until a_ready
  // RD_B   | kernel read strobe
  // CAP_B  | capture kernel word into b_input, raise b_valid
  // HOLD_B | hold b beat until b_ready, then advance loop counters
  // FIN    | one-cycle done pulse

  localparam int W   = FEATURE_MAP_WIDTH;
  localparam int H   = FEATURE_MAP_HEIGHT;
  localparam int CI  = INPUT_NB_CHANNELS;
  localparam int CO  = OUTPUT_NB_CHANNELS;
  localparam int K   = KERNEL_SIZE;
  localparam int AW  = ADDR_WIDTH;
  localparam int OW  = (W + STRIDE - 1) / STRIDE;
  localparam int OH  = (H + STRIDE - 1) / STRIDE;
  localparam int MWH = (W > H) ? W : H;
  localparam int CW  = $clog2(MWH) + 2;
  localparam int KW  = $clog2(K) + 1;
  localparam int CIW = $clog2(CI) + 1;
  localparam int COW = $clog2(CO) + 1;
  localparam logic signed [CW-1:0] W_S = CW'(W);
  localparam logic signed [CW-1:0] H_S = CW'(H);

  typedef enum logic [2:0] {IDLE, RD_A, CAP_A, HOLD_A, RD_B, CAP_B, HOLD_B, FIN} state_t;
  state_t state_q, state_d;

  logic           mode_q;
  logic [CW-1:0]  ox_q, oy_q;
  logic [CIW-1:0] inch_q;
  logic [COW-1:0] outch_q;
  logic [KW-1:0]  ky_q, kx_q;

  logic [KW-1:0]         kmax;
  logic [CW-1:0]         half;
  logic signed [CW-1:0]  ix, iy;
  logic                  in_bounds;
  logic [AW-1:0]         kdim, fm_addr_c, k_addr_c;
  logic kx_last, ky_last, outch_last, inch_last, oy_last, ox_last, last_tap;

  // Matmul collapses the kernel to a single centred tap, which also removes all padding.
  assign kmax = mode_q ? KW'(K - 1) : '0;
  assign half = mode_q ? CW'(K / 2) : '0;
  assign kdim = mode_q ? AW'(K) : AW'(1);

  assign ix = ox_q * CW'(STRIDE) + CW'(kx_q) - half;
  assign iy = oy_q * CW'(STRIDE) + CW'(ky_q) - half;
  assign in_bounds = !ix[CW-1] && (ix < W_S) && !iy[CW-1] && (iy < H_S);

  assign fm_addr_c = (AW'($unsigned(iy)) * AW'(W) + AW'($unsigned(ix))) * AW'(CI) + AW'(inch_q);
  assign k_addr_c  = ((AW'(ky_q) * kdim + AW'(kx_q)) * AW'(CI) + AW'(inch_q)) * AW'(CO)
                     + AW'(outch_q);

  assign kx_last    = (kx_q == kmax);
  assign ky_last    = (ky_q == kmax);
  assign outch_last = (outch_q == COW'(CO - 1));
  assign inch_last  = (inch_q == CIW'(CI - 1));
  assign oy_last    = (oy_q == CW'(OH - 1));
  assign ox_last    = (ox_q == CW'(OW - 1));
  assign last_tap   = kx_last && ky_last && outch_last && inch_last && oy_last && ox_last;

  assign fm_addr = fm_rd_en ? fm_addr_c : '0;
  assign k_addr  = k_rd_en ? k_addr_c : '0;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    fm_rd_en = 1'b0;
    k_rd_en  = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = RD_A;
      RD_A:    begin fm_rd_en = in_bounds; state_d = CAP_A; end
      CAP_A:   state_d = HOLD_A;
      HOLD_A:  if (a_ready) state_d = RD_B;
      RD_B:    begin k_rd_en = 1'b1; state_d = CAP_B; end
      CAP_B:   state_d = HOLD_B;
      HOLD_B:  if (b_ready) state_d = last_tap ? FIN : RD_A;
      FIN:     begin done = 1'b1; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      mode_q  <= 1'b0;
      ox_q    <= '0;
      oy_q    <= '0;
      inch_q  <= '0;
      outch_q <= '0;
      ky_q    <= '0;
      kx_q    <= '0;
      running <= 1'b0;
      a_input <= '0;
      a_valid <= 1'b0;
      b_input <= '0;
      b_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mode_q  <= conv_mode;
          ox_q    <= '0;
          oy_q    <= '0;
          inch_q  <= '0;
          outch_q <= '0;
          ky_q    <= '0;
          kx_q    <= '0;
          running <= 1'b1;
        end
        CAP_A: begin
          a_input <= in_bounds ? fm_rdata : '0;
          a_valid <= 1'b1;
        end
        HOLD_A: if (a_ready) a_valid <= 1'b0;
        CAP_B: begin
          b_input <= k_rdata;
          b_valid <= 1'b1;
        end
        HOLD_B: if (b_ready) begin
          b_valid <= 1'b0;
          if (!kx_last) kx_q <= kx_q + 1'b1;
          else begin
            kx_q <= '0;
            if (!ky_last) ky_q <= ky_q + 1'b1;
            else begin
              ky_q <= '0;
              if (!outch_last) outch_q <= outch_q + 1'b1;
              else begin
                outch_q <= '0;
                if (!inch_last) inch_q <= inch_q + 1'b1;
                else begin
                  inch_q <= '0;
                  if (!oy_last) oy_q <= oy_q + 1'b1;
                  else begin
                    oy_q <= '0;
                    ox_q <= ox_last ? '0 : ox_q + 1'b1;
                  end
                end
              end
            end
          end
        end
        FIN: running <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef CONV_SEQ_PERF_EN
  logic stall;
  assign stall = ((state_q == HOLD_A) && !a_ready) || ((state_q == HOLD_B) && !b_ready);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if ((state_q == IDLE) && start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (running && (perf_cycles != '1)) perf_cycles <= perf_cycles + 32'd1;
      if (stall && (perf_stalls != '1))   perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_operand_sequencer.sv
// Bench for conv_operand_sequencer: three differently parameterised instances checked
// against a div/mod tap model, plus directed backpressure, restart and reset-abort sequences.
module tb_conv_operand_sequencer;

  localparam int NI = 3;
  localparam int DW = 16;
  localparam int AW = 20;
  localparam int P_W  [NI] = '{4, 4, 2};
  localparam int P_H  [NI] = '{4, 4, 2};
  localparam int P_CI [NI] = '{1, 1, 2};
  localparam int P_CO [NI] = '{1, 1, 3};
  localparam int P_K  [NI] = '{3, 3, 3};
  localparam int P_S  [NI] = '{1, 2, 1};
  localparam int MAXT = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NI-1:0] start, conv_mode, a_ready, b_ready;
  logic [NI-1:0] running, done, fm_rd_en, k_rd_en, a_valid, b_valid;
  logic [NI-1:0][AW-1:0] fm_addr, k_addr;
  logic [NI-1:0][DW-1:0] a_input, b_input;
`ifdef CONV_SEQ_PERF_EN
  logic [NI-1:0][31:0] perf_cycles, perf_stalls;
`endif

  function automatic logic [DW-1:0] fm_word(input logic [AW-1:0] ad);
    return {4'hA, ad[11:0]};
  endfunction
  function automatic logic [DW-1:0] k_word(input logic [AW-1:0] ad);
    return {4'h5, ad[11:0]};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [DW-1:0] fm_q, k_q;
    always @(posedge clk) begin
      if (fm_rd_en[g]) fm_q <= fm_word(fm_addr[g]);
      if (k_rd_en[g])  k_q  <= k_word(k_addr[g]);
    end
    conv_operand_sequencer #(
      .IO_DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(P_W[g]), .FEATURE_MAP_HEIGHT(P_H[g]),
      .INPUT_NB_CHANNELS(P_CI[g]), .OUTPUT_NB_CHANNELS(P_CO[g]), .KERNEL_SIZE(P_K[g]),
      .STRIDE(P_S[g]), .ADDR_WIDTH(AW)
    ) u_dut (
      .clk(clk), .arst_n_in(rst_n), .start(start[g]), .conv_mode(conv_mode[g]),
      .running(running[g]), .done(done[g]),
      .fm_rd_en(fm_rd_en[g]), .fm_addr(fm_addr[g]), .fm_rdata(fm_q),
      .k_rd_en(k_rd_en[g]), .k_addr(k_addr[g]), .k_rdata(k_q),
      .a_input(a_input[g]), .a_valid(a_valid[g]), .a_ready(a_ready[g]),
      .b_input(b_input[g]), .b_valid(b_valid[g]), .b_ready(b_ready[g])
`ifdef CONV_SEQ_PERF_EN
      , .perf_cycles(perf_cycles[g]), .perf_stalls(perf_stalls[g])
`endif
    );
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h t=%0t", name, g, act, exp, $time);
    end
  endtask

  // Reference model: decode a flat tap index into loop coordinates with div/mod.
  function automatic int n_taps(input int g, input logic m);
    int kk;
    kk = m ? P_K[g] : 1;
    return ((P_W[g] + P_S[g] - 1) / P_S[g]) * ((P_H[g] + P_S[g] - 1) / P_S[g])
           * P_CI[g] * P_CO[g] * kk * kk;
  endfunction

  function automatic void tap_model(input int g, input logic m, input int t,
                                    output logic pad, output int fa, output int ka);
    int kk, half, oh, r, kx, ky, oc, ic, oy, ox, ix, iy;
    kk = m ? P_K[g] : 1;
    half = kk / 2;
    oh = (P_H[g] + P_S[g] - 1) / P_S[g];
    r = t;
    kx = r % kk;      r = r / kk;
    ky = r % kk;      r = r / kk;
    oc = r % P_CO[g]; r = r / P_CO[g];
    ic = r % P_CI[g]; r = r / P_CI[g];
    oy = r % oh;
    ox = r / oh;
    ix = ox * P_S[g] + kx - half;
    iy = oy * P_S[g] + ky - half;
    pad = (ix < 0) || (ix >= P_W[g]) || (iy < 0) || (iy >= P_H[g]);
    fa = (iy * P_W[g] + ix) * P_CI[g] + ic;
    ka = ((ky * kk + kx) * P_CI[g] + ic) * P_CO[g] + oc;
  endfunction

  int a_cnt [NI], b_cnt [NI], rd_tap [NI], done_cnt [NI], run_cyc [NI], stall_cyc [NI];
  logic run_mode [NI];
  logic prev_av [NI], prev_ar [NI], prev_bv [NI], prev_br [NI];
  logic [DW-1:0] prev_a [NI], prev_b [NI];
  logic obs_rd [NI][MAXT];
  logic [AW-1:0] obs_fa [NI][MAXT], obs_ka [NI][MAXT];
  logic [DW-1:0] obs_a [NI][MAXT];

  task automatic clear_mon(input int g);
    a_cnt[g] = 0; b_cnt[g] = 0; rd_tap[g] = 0; done_cnt[g] = 0;
    run_cyc[g] = 0; stall_cyc[g] = 0;
    prev_av[g] = 1'b0; prev_ar[g] = 1'b0; prev_bv[g] = 1'b0; prev_br[g] = 1'b0;
    for (int t = 0; t < MAXT; t++) begin
      obs_rd[g][t] = 1'b0; obs_fa[g][t] = '0; obs_ka[g][t] = '0; obs_a[g][t] = '0;
    end
  endtask

  // Judges the edge about to happen from the current (stable) outputs and applied inputs.
  task automatic monitor();
    logic pad;
    int fa, ka, t;
    for (int g = 0; g < NI; g++) begin
      check("a_b_valid_exclusive", g, 32'(a_valid[g] & b_valid[g]), 0);
      if (prev_av[g] && !prev_ar[g]) begin
        check("a_valid_held", g, 32'(a_valid[g]), 1);
        check("a_input_held", g, 32'(a_input[g]), 32'(prev_a[g]));
      end
      if (prev_bv[g] && !prev_br[g]) begin
        check("b_valid_held", g, 32'(b_valid[g]), 1);
        check("b_input_held", g, 32'(b_input[g]), 32'(prev_b[g]));
      end
      if (running[g]) run_cyc[g]++;
      if ((a_valid[g] && !a_ready[g]) || (b_valid[g] && !b_ready[g])) stall_cyc[g]++;
      if (fm_rd_en[g]) begin
        t = a_cnt[g];
        tap_model(g, run_mode[g], t, pad, fa, ka);
        check("fm_read_on_padded_tap", g, 32'(pad), 0);
        check("fm_addr", g, 32'(fm_addr[g]), 32'(AW'(fa)));
        rd_tap[g]++;
        if (t < MAXT) begin obs_rd[g][t] = 1'b1; obs_fa[g][t] = fm_addr[g]; end
      end
      if (k_rd_en[g]) begin
        t = b_cnt[g];
        tap_model(g, run_mode[g], t, pad, fa, ka);
        check("k_addr", g, 32'(k_addr[g]), 32'(AW'(ka)));
        if (t < MAXT) obs_ka[g][t] = k_addr[g];
      end
      if (a_valid[g] && a_ready[g]) begin
        t = a_cnt[g];
        check("a_beat_in_range", g, 32'(t < n_taps(g, run_mode[g])), 1);
        tap_model(g, run_mode[g], t, pad, fa, ka);
        check("a_input", g, 32'(a_input[g]), pad ? 32'd0 : 32'(fm_word(AW'(fa))));
        check("fm_reads_per_tap", g, 32'(rd_tap[g]), pad ? 32'd0 : 32'd1);
        if (t < MAXT) obs_a[g][t] = a_input[g];
        a_cnt[g]++;
        rd_tap[g] = 0;
      end
      if (b_valid[g] && b_ready[g]) begin
        t = b_cnt[g];
        tap_model(g, run_mode[g], t, pad, fa, ka);
        check("b_input", g, 32'(b_input[g]), 32'(k_word(AW'(ka))));
        b_cnt[g]++;
      end
      if (done[g]) begin
        done_cnt[g]++;
        check("done_after_last_b", g, 32'(b_cnt[g]), 32'(n_taps(g, run_mode[g])));
      end
      prev_av[g] = a_valid[g]; prev_ar[g] = a_ready[g]; prev_a[g] = a_input[g];
      prev_bv[g] = b_valid[g]; prev_br[g] = b_ready[g]; prev_b[g] = b_input[g];
    end
  endtask

  task automatic cycle();
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    for (int g = 0; g < NI; g++) begin
      check({name, "_ctrl"}, g,
            32'({running[g], done[g], fm_rd_en[g], k_rd_en[g], a_valid[g], b_valid[g]}), 0);
      check({name, "_a_input"}, g, 32'(a_input[g]), 0);
      check({name, "_b_input"}, g, 32'(b_input[g]), 0);
      check({name, "_fm_addr"}, g, 32'(fm_addr[g]), 0);
      check({name, "_k_addr"},  g, 32'(k_addr[g]), 0);
    end
  endtask

  typedef struct {
    int   g;
    logic mode;
    logic rnd;
    logic mid_start;
    int   stall_a_tap;
    int   stall_b_tap;
    int   exp_pairs;
  } run_vec_t;

  typedef struct {
    int            g;
    int            tap;
    logic          rd;
    logic [AW-1:0] fa;
    logic [AW-1:0] ka;
    logic [DW-1:0] a;
  } spot_t;

  task automatic do_run(input run_vec_t v);
    int g, sa, sb;
    logic seen;
    g = v.g;
    clear_mon(g);
    run_mode[g] = v.mode;
    conv_mode[g] = v.mode;
    a_ready[g] = 1'b1;
    b_ready[g] = 1'b1;
    start[g] = 1'b1;
    cycle();
    start[g] = 1'b0;
    check("running_after_start", g, 32'(running[g]), 1);
    sa = 0; sb = 0; seen = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      a_ready[g] = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      b_ready[g] = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (v.stall_a_tap >= 0 && a_valid[g] && a_cnt[g] == v.stall_a_tap && sa < 5) begin
        a_ready[g] = 1'b0; sa++;
      end
      if (v.stall_b_tap >= 0 && b_valid[g] && b_cnt[g] == v.stall_b_tap && sb < 5) begin
        b_ready[g] = 1'b0; sb++;
      end
      start[g] = v.mid_start && (c == 40);
      seen = done[g];
      cycle();
    end
    start[g] = 1'b0;
    a_ready[g] = 1'b1;
    b_ready[g] = 1'b1;
    check("run_done_within_budget", g, 32'(seen), 1);
    check("a_beat_count", g, 32'(a_cnt[g]), 32'(v.exp_pairs));
    check("b_beat_count", g, 32'(b_cnt[g]), 32'(v.exp_pairs));
    check("running_low_after_done", g, 32'(running[g]), 0);
`ifdef CONV_SEQ_PERF_EN
    check("perf_cycles", g, perf_cycles[g], 32'(run_cyc[g]));
    check("perf_stalls", g, perf_stalls[g], 32'(stall_cyc[g]));
    if (!v.rnd)
      check("perf_stalls_injected", g, perf_stalls[g],
            32'(5 * (int'(v.stall_a_tap >= 0) + int'(v.stall_b_tap >= 0))));
`endif
    for (int c = 0; c < 3; c++) cycle();
    check("done_pulse_count", g, 32'(done_cnt[g]), 1);
    check("running_idle", g, 32'(running[g]), 0);
  endtask

  run_vec_t runs [8];
  spot_t    spots [9];

  initial begin
    #3000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    runs[0] = '{0, 1'b1, 1'b0, 1'b0, -1, -1, 144};
    runs[1] = '{1, 1'b1, 1'b0, 1'b0, -1, -1, 36};
    runs[2] = '{2, 1'b0, 1'b0, 1'b0, -1, -1, 24};
    runs[3] = '{0, 1'b1, 1'b0, 1'b1,  7, 12, 144};
    runs[4] = '{1, 1'b1, 1'b1, 1'b1, -1, -1, 36};
    runs[5] = '{2, 1'b1, 1'b1, 1'b0, -1, -1, 216};
    runs[6] = '{2, 1'b0, 1'b1, 1'b0,  3, -1, 24};
    runs[7] = '{0, 1'b1, 1'b0, 1'b0, 20, -1, 144};

    spots[0] = '{0, 0,  1'b0, 20'd0, 20'd0, 16'h0000};
    spots[1] = '{0, 4,  1'b1, 20'd0, 20'd4, 16'hA000};
    spots[2] = '{1, 22, 1'b1, 20'd2, 20'd4, 16'hA002};
    spots[3] = '{2, 0,  1'b1, 20'd0, 20'd0, 16'hA000};
    spots[4] = '{2, 1,  1'b1, 20'd0, 20'd1, 16'hA000};
    spots[5] = '{2, 2,  1'b1, 20'd0, 20'd2, 16'hA000};
    spots[6] = '{2, 3,  1'b1, 20'd1, 20'd3, 16'hA001};
    spots[7] = '{2, 4,  1'b1, 20'd1, 20'd4, 16'hA001};
    spots[8] = '{2, 5,  1'b1, 20'd1, 20'd5, 16'hA001};

    start = '0; conv_mode = '0; a_ready = '1; b_ready = '1;
    for (int g = 0; g < NI; g++) begin clear_mon(g); run_mode[g] = 1'b0; end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) cycle();

    for (int i = 0; i < 8; i++) do_run(runs[i]);

    foreach (spots[i]) begin
      check("spot_fm_rd", spots[i].g, 32'(obs_rd[spots[i].g][spots[i].tap]), 32'(spots[i].rd));
      if (spots[i].rd)
        check("spot_fm_addr", spots[i].g, 32'(obs_fa[spots[i].g][spots[i].tap]), 32'(spots[i].fa));
      check("spot_k_addr", spots[i].g, 32'(obs_ka[spots[i].g][spots[i].tap]), 32'(spots[i].ka));
      check("spot_a_input", spots[i].g, 32'(obs_a[spots[i].g][spots[i].tap]), 32'(spots[i].a));
    end

    // Abort a conv run at tap 50 with reset, then restart cleanly.
    clear_mon(0);
    run_mode[0] = 1'b1;
    conv_mode[0] = 1'b1;
    start[0] = 1'b1;
    cycle();
    start[0] = 1'b0;
    for (int c = 0; c < 5000 && a_cnt[0] < 50; c++) cycle();
    check("reached_tap_50", 0, 32'(a_cnt[0]), 50);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_run");
    for (int g = 0; g < NI; g++) clear_mon(g);
    for (int c = 0; c < 3; c++) cycle();
    check("no_done_on_abort", 0, 32'(done_cnt[0]), 0);
    check("running_low_in_reset", 0, 32'(running[0]), 0);
    rst_n = 1'b1;
    cycle();
    do_run(runs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_operand_sequencer.md
Name: conv_operand_sequencer

Overview:
Synthesizable operand streamer for the top_system CONV/MAC datapath. Walks the output-position / channel / kernel-tap loop nest, fetches feature-map and kernel words from two single-port read memories, and streams them over the a/b valid-ready interface (one a beat then one b beat per tap). Zero-padding is applied in hardware. Compared with the fixed-order bench driver, it adds parametrised stride, padding width, channel counts, backpressure tolerance and a matmul mode.

Parameters:
IO_DATA_WIDTH, 16, operand width
FEATURE_MAP_WIDTH, 128, input FM width (W)
FEATURE_MAP_HEIGHT, 128, input FM height (H)
INPUT_NB_CHANNELS, 2, input channels (CI)
OUTPUT_NB_CHANNELS, 16, output channels (CO)
KERNEL_SIZE, 3, square kernel side (K), odd, ≥1
STRIDE, 1, output step in input pixels, ≥1
ADDR_WIDTH, 20, memory address width

Ports:
clk  in  1  clock
arst_n_in  in  1  async active-low reset
start  in  1  one-cycle start pulse
conv_mode  in  1  1=conv, 0=matmul (K forced to 1, no padding); sampled at start
running  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse after last b beat accepted
fm_rd_en  out  1  feature-map read strobe
fm_addr  out  ADDR_WIDTH  feature-map word address
fm_rdata  in  IO_DATA_WIDTH  read data, valid 1 cycle after fm_rd_en
k_rd_en  out  1  kernel read strobe
k_addr  out  ADDR_WIDTH  kernel word address
k_rdata  in  IO_DATA_WIDTH  read data, valid 1 cycle after k_rd_en
a_input  out  IO_DATA_WIDTH  feature operand
a_valid  out  1  a beat valid
a_ready  in  1  a beat accept
b_input  out  IO_DATA_WIDTH  weight operand
b_valid  out  1  b beat valid
b_ready  in  1  b beat accept

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0. Asserting reset mid-run aborts immediately; there is no done pulse.
- Loop order, outer to inner: ox, oy, inch, outch, ky, kx. OW=ceil(W/STRIDE), OH=ceil(H/STRIDE). Kx is used as the effective kernel size (K in conv, 1 in matmul).
- Input coordinate: ix=ox*STRIDE+kx-Kx/2, iy=oy*STRIDE+ky-Kx/2. Evaluate in signed width, with 2 bits of margin over $clog2(max(W,H)).
- Padding: if ix<0, ix≥W, iy<0 or iy≥H, no fm read is issued and a_input=0.
- Addresses: fm_addr=(iy*W+ix)*CI+inch; k_addr=((ky*Kx+kx)*CI+inch)*CO+outch. Truncate to ADDR_WIDTH.
- FSM states: IDLE, RD_A, CAP_A, HOLD_A, RD_B, CAP_B, HOLD_B, FIN.
- IDLE: on start go to RD_A and set running=1. start is ignored in all other states.
- RD_A: pulse fm_rd_en=1 only if the tap is in-bounds, then go to CAP_A.
- CAP_A: a_input<=fm_rdata (or 0 if padded); a_valid<=1; go to HOLD_A.
- HOLD_A: hold a_input and a_valid stable until a_valid&&a_ready. In that cycle, a_valid<=0 and go to RD_B.
- RD_B, CAP_B, HOLD_B mirror the a side using k_rd_en, k_rdata and b. On b handshake, advance the loop counters: RD_A if taps remain, else FIN.
- FIN: done=1 for one cycle, running<=0, then IDLE.
- Per-tap minimum latency is 6 cycles. a_valid and b_valid are never high together. Data must not change while valid is high and ready is low.
- Counter wrap: kx wraps into ky, ky into outch, outch into inch, inch into oy, oy into ox. The last tap is reached when all counters are at their maxima.
- ready asserted before valid is ignored; no beat is counted.

Optional Feature:
CONV_SEQ_PERF_EN:
- Defined: adds outputs perf_cycles[31:0] and perf_stalls[31:0].
- perf_cycles counts cycles with running=1.
- perf_stalls counts cycles in HOLD_A/HOLD_B with ready=0.
- Both counters clear on accepted start, hold after done, and saturate at all-ones.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Conv, W=H=4, CI=CO=1, K=3, STRIDE=1, ready tied 1 -> exactly 144 a and 144 b beats; done once. First tap (ox=oy=0,ky=kx=0) gives a_input=0 with no fm_rd_en. Tap ky=kx=1 reads fm_addr=0.
- Same config with STRIDE=2 -> OW=OH=2, 36 beat pairs. Tap (ox=1,oy=0,ky=1,kx=1) reads fm_addr=2.
- Matmul (conv_mode=0), W=H=2, CI=2, CO=3 -> 24 pairs. Every tap in-bounds. k_addr sequence for first pixel: 0,1,2,3,4,5.
- Backpressure: hold a_ready=0 for 5 cycles in HOLD_A -> a_valid=1 and a_input stable throughout, with no fm_rd_en re-issue. Same check on the b side.
- start pulsed while running -> ignored, with beat counts unchanged. Reset asserted at tap 50 -> all outputs 0 within the same cycle, no done. New start then gives a full 144-pair run.
- CONV_SEQ_PERF_EN with 5-cycle stall injected on one beat -> perf_stalls=5, and perf_cycles equals the measured running duration.
